// File: rtl/decode_exe_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : decode_pkg
//  Desc     : Shared parameters, control-bundle field offsets and state type
//             for the decode-to-execute pipeline slice.
//  Revision : 1.0
// ============================================================================
package decode_pkg;

  localparam int DATA_W = 32;
  localparam int RA_W   = 4;
  localparam int N_SRC  = 3;
  localparam int CTRL_W = 16;
  localparam int CNT_W  = 16;

  // Program counter alias: its architectural value is not in the regfile,
  // so writeback data for this address must never be forwarded.
  localparam logic [RA_W-1:0] PC_REG = {RA_W{1'b1}};

  // Control bundle layout (opaque to this stage, carried through unchanged)
  localparam int CTRL_ALUCTRL_LSB = 0;   // 4 bits
  localparam int CTRL_ALUSRC_BIT  = 4;
  localparam int CTRL_REGWR_BIT   = 5;
  localparam int CTRL_MEM2REG_BIT = 6;
  localparam int CTRL_BRANCH_BIT  = 7;
  localparam int CTRL_PCSRC_BIT   = 8;
  localparam int CTRL_PLUSONE_BIT = 9;
  localparam int CTRL_COND_LSB    = 10;  // 4 bits, [15:14] reserved

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/decode_exe_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : decode_exe_pipe_if
//  Desc     : Decode, execute, writeback and status signals of the
//             decode-to-execute slice. master = surrounding pipeline,
//             slave = the slice itself.
//  Revision : 1.0
// ============================================================================
interface decode_exe_pipe_if;
  import decode_pkg::*;

  // decode side
  logic                    d_valid;
  logic                    d_ready;
  logic [N_SRC*DATA_W-1:0] d_rd;
  logic [N_SRC*RA_W-1:0]   d_ra;
  logic [N_SRC-1:0]        d_ra_used;
  logic [DATA_W-1:0]       d_imm;
  logic [RA_W-1:0]         d_wa;
  logic [CTRL_W-1:0]       d_ctrl;
  logic                    d_is_load;
  logic                    flush;
  // execute side
  logic                    e_valid;
  logic                    e_ready;
  logic [N_SRC*DATA_W-1:0] e_rd;
  logic [DATA_W-1:0]       e_imm;
  logic [RA_W-1:0]         e_wa;
  logic [CTRL_W-1:0]       e_ctrl;
  logic                    e_is_load;
  // writeback bypass
  logic                    wb_we;
  logic [RA_W-1:0]         wb_wa;
  logic [DATA_W-1:0]       wb_wd;
  // status
  logic                    hazard;
  logic [CNT_W-1:0]        stall_cnt;

  modport master (
    output d_valid, d_rd, d_ra, d_ra_used, d_imm, d_wa, d_ctrl, d_is_load, flush,
    output e_ready, wb_we, wb_wa, wb_wd,
    input  d_ready, e_valid, e_rd, e_imm, e_wa, e_ctrl, e_is_load, hazard, stall_cnt
  );

  modport slave (
    input  d_valid, d_rd, d_ra, d_ra_used, d_imm, d_wa, d_ctrl, d_is_load, flush,
    input  e_ready, wb_we, wb_wa, wb_wd,
    output d_ready, e_valid, e_rd, e_imm, e_wa, e_ctrl, e_is_load, hazard, stall_cnt
  );

endinterface
`default_nettype wire

// File: rtl/decode_exe_pipe_hazard.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_detect
//  Desc     : Combinational source/destination comparator. Flags a load-use
//             hazard and produces per-slot writeback-forwarding vectors for
//             both the incoming and the held instruction.
//  Revision : 1.0
// ============================================================================
module hazard_detect
  import decode_pkg::*;
(
  input  logic                  d_valid_i,
  input  logic                  e_valid_i,
  input  logic                  e_is_load_i,
  input  logic                  flush_i,
  input  logic [N_SRC*RA_W-1:0] d_ra_i,
  input  logic [N_SRC-1:0]      d_ra_used_i,
  input  logic [RA_W-1:0]       e_wa_i,
  input  logic [N_SRC*RA_W-1:0] hold_ra_i,
  input  logic [N_SRC-1:0]      hold_used_i,
  input  logic                  wb_we_i,
  input  logic [RA_W-1:0]       wb_wa_i,
  output logic                  hazard_o,
  output logic [N_SRC-1:0]      cap_byp_o,
  output logic [N_SRC-1:0]      hold_byp_o
);

  logic [N_SRC-1:0] load_match;
  logic             wb_fwd_ok;

  // PC alias is never forwarded, whichever slot names it
  assign wb_fwd_ok = wb_we_i & (wb_wa_i != PC_REG);

  genvar i;
  generate
    for (i = 0; i < N_SRC; i++) begin : g_slot
      assign load_match[i] = d_ra_used_i[i] & (d_ra_i[i*RA_W +: RA_W] == e_wa_i);
      assign cap_byp_o[i]  = wb_fwd_ok & d_ra_used_i[i] & (d_ra_i[i*RA_W +: RA_W] == wb_wa_i);
      assign hold_byp_o[i] = wb_fwd_ok & hold_used_i[i] & (hold_ra_i[i*RA_W +: RA_W] == wb_wa_i);
    end
  endgenerate

  assign hazard_o = d_valid_i & e_valid_i & e_is_load_i & ~flush_i & (|load_match);

endmodule
`default_nettype wire

// File: rtl/decode_exe_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : decode_exe_pipe
//  Desc     : Two-state decode-to-execute register slice with load-use stall,
//             writeback bypass at capture and while holding, flush, and a
//             saturating stall counter.
//  Revision : 1.0
// ============================================================================
module decode_exe_pipe
  import decode_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  decode_exe_pipe_if.slave bus
);

  state_t                  state_q;
  logic [N_SRC*DATA_W-1:0] rd_q;
  logic [DATA_W-1:0]       imm_q;
  logic [RA_W-1:0]         wa_q;
  logic [CTRL_W-1:0]       ctrl_q;
  logic                    is_load_q;
  logic [N_SRC*RA_W-1:0]   ra_q;
  logic [N_SRC-1:0]        used_q;
  logic [CNT_W-1:0]        stall_q;

  logic [N_SRC*DATA_W-1:0] cap_rd_d;
  logic [N_SRC*DATA_W-1:0] hold_rd_d;
  logic [N_SRC-1:0]        cap_byp;
  logic [N_SRC-1:0]        hold_byp;
  logic                    hazard_raw;
  logic                    hazard;
  logic                    d_ready;
  logic                    e_valid;
  logic                    capture;

  assign e_valid = (state_q == FULL);

  hazard_detect u_hazard (
    .d_valid_i   (bus.d_valid),
    .e_valid_i   (e_valid),
    .e_is_load_i (is_load_q),
    .flush_i     (bus.flush),
    .d_ra_i      (bus.d_ra),
    .d_ra_used_i (bus.d_ra_used),
    .e_wa_i      (wa_q),
    .hold_ra_i   (ra_q),
    .hold_used_i (used_q),
    .wb_we_i     (bus.wb_we),
    .wb_wa_i     (bus.wb_wa),
    .hazard_o    (hazard_raw),
    .cap_byp_o   (cap_byp),
    .hold_byp_o  (hold_byp)
  );

  // Handshake is suppressed entirely while reset is held
  assign hazard  = reset & hazard_raw;
  assign d_ready = reset & (bus.flush | ((~e_valid | bus.e_ready) & ~hazard));
  assign capture = bus.d_valid & d_ready & ~bus.flush;

  // Operand muxes: forward writeback data into matching slots
  always_comb begin
    cap_rd_d  = bus.d_rd;
    hold_rd_d = rd_q;
    for (int i = 0; i < N_SRC; i++) begin
      if (cap_byp[i])  cap_rd_d[i*DATA_W +: DATA_W]  = bus.wb_wd;
      if (hold_byp[i]) hold_rd_d[i*DATA_W +: DATA_W] = bus.wb_wd;
    end
  end

  // Slice FSM: flush beats capture, capture beats drain, drain beats hold
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= EMPTY;
      rd_q      <= '0;
      imm_q     <= '0;
      wa_q      <= '0;
      ctrl_q    <= '0;
      is_load_q <= 1'b0;
      ra_q      <= '0;
      used_q    <= '0;
    end else if (bus.flush) begin
      state_q <= EMPTY;
    end else if (capture) begin
      state_q   <= FULL;
      rd_q      <= cap_rd_d;
      imm_q     <= bus.d_imm;
      wa_q      <= bus.d_wa;
      ctrl_q    <= bus.d_ctrl;
      is_load_q <= bus.d_is_load;
      ra_q      <= bus.d_ra;
      used_q    <= bus.d_ra_used;
    end else if (e_valid && bus.e_ready) begin
      state_q <= EMPTY;
    end else if (e_valid) begin
      rd_q <= hold_rd_d;
    end
  end

  // Saturating count of load-use stall cycles
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (hazard && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign bus.d_ready   = d_ready;
  assign bus.hazard    = hazard;
  assign bus.e_valid   = e_valid;
  assign bus.e_rd      = rd_q;
  assign bus.e_imm     = imm_q;
  assign bus.e_wa      = wa_q;
  assign bus.e_ctrl    = ctrl_q;
  assign bus.e_is_load = is_load_q;
  assign bus.stall_cnt = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_exe_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decode_exe_pipe
//  Desc     : Directed self-checking bench for decode_exe_pipe with a
//             transfer scoreboard.
//  Revision : 1.0
// ============================================================================
module tb_decode_exe_pipe;
  import decode_pkg::*;

  typedef struct packed {
    logic [95:0] rd;
    logic [11:0] ra;
    logic [2:0]  used;
    logic [31:0] imm;
    logic [3:0]  wa;
    logic [15:0] ctrl;
    logic        ld;
  } instr_t;

  typedef struct packed {
    logic [95:0] rd;
    logic [31:0] imm;
    logic [3:0]  wa;
    logic [15:0] ctrl;
    logic        ld;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  decode_exe_pipe_if bus();

  decode_exe_pipe dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic instr_t mk(input logic [31:0] r2, r1, r0, input logic [3:0] a2, a1, a0,
                                input logic [2:0] used, input logic [31:0] imm,
                                input logic [3:0] wa, input logic [15:0] ctrl, input logic ld);
    instr_t x;
    x.rd = {r2, r1, r0}; x.ra = {a2, a1, a0}; x.used = used;
    x.imm = imm; x.wa = wa; x.ctrl = ctrl; x.ld = ld;
    return x;
  endfunction

  // Reference: what execute should see for an instruction captured now
  function automatic exp_t model(input instr_t x, input logic we, input logic [3:0] wwa,
                                 input logic [31:0] wwd);
    exp_t e;
    e.rd = x.rd; e.imm = x.imm; e.wa = x.wa; e.ctrl = x.ctrl; e.ld = x.ld;
    for (int i = 0; i < 3; i++)
      if (we && x.used[i] && (x.ra[i*4 +: 4] == wwa) && (wwa != 4'hF))
        e.rd[i*32 +: 32] = wwd;
    return e;
  endfunction

  task automatic drive(input instr_t x);
    bus.d_valid = 1'b1; bus.d_rd = x.rd; bus.d_ra = x.ra; bus.d_ra_used = x.used;
    bus.d_imm = x.imm; bus.d_wa = x.wa; bus.d_ctrl = x.ctrl; bus.d_is_load = x.ld;
  endtask

  task automatic drive_push(input instr_t x);
    drive(x);
    sb.push_back(model(x, bus.wb_we, bus.wb_wa, bus.wb_wd));
  endtask

  // Scoreboard: every execute-side transfer must match the oldest expectation
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.e_valid === 1'b1 && bus.e_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", {127'd0, bus.e_valid}, 128'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_rd",   {32'd0, bus.e_rd}, {32'd0, e.rd});
        chk("sb_imm",  {96'd0, bus.e_imm}, {96'd0, e.imm});
        chk("sb_wa",   {124'd0, bus.e_wa}, {124'd0, e.wa});
        chk("sb_ctrl", {112'd0, bus.e_ctrl}, {112'd0, e.ctrl});
        chk("sb_ld",   {127'd0, bus.e_is_load}, {127'd0, e.ld});
      end
    end
  end

  initial begin
    instr_t x;
    exp_t   t;
    reset = 1'b0;
    bus.d_valid = 1'b1; bus.d_rd = '0; bus.d_ra = '0; bus.d_ra_used = '0; bus.d_imm = '0;
    bus.d_wa = '0; bus.d_ctrl = '0; bus.d_is_load = 1'b0; bus.flush = 1'b1;
    bus.e_ready = 1'b1; bus.wb_we = 1'b0; bus.wb_wa = '0; bus.wb_wd = '0;

    // Reset state
    tick(); tick();
    chk("rst_e_valid", {127'd0, bus.e_valid}, 128'd0);
    chk("rst_e_rd",    {32'd0, bus.e_rd}, 128'd0);
    chk("rst_e_imm",   {96'd0, bus.e_imm}, 128'd0);
    chk("rst_e_wa",    {124'd0, bus.e_wa}, 128'd0);
    chk("rst_e_ctrl",  {112'd0, bus.e_ctrl}, 128'd0);
    chk("rst_stall",   {112'd0, bus.stall_cnt}, 128'd0);
    chk("rst_d_ready", {127'd0, bus.d_ready}, 128'd0);
    chk("rst_hazard",  {127'd0, bus.hazard}, 128'd0);

    // Single transfer, latency 1
    reset = 1'b1; bus.flush = 1'b0; bus.d_valid = 1'b0;
    tick();
    x = mk(32'h33, 32'h22, 32'h11, 4'd3, 4'd2, 4'd1, 3'b111, 32'h100, 4'd2, 16'h0021, 1'b0);
    drive_push(x);
    #1 chk("a_d_ready", {127'd0, bus.d_ready}, 128'd1);
    tick();
    chk("a_e_valid", {127'd0, bus.e_valid}, 128'd1);
    bus.d_valid = 1'b0;
    tick();
    chk("a_drained", {127'd0, bus.e_valid}, 128'd0);

    // Back-to-back: capture while draining in FULL stays FULL
    drive_push(mk(32'h1, 32'h2, 32'h3, 4'd4, 4'd5, 4'd6, 3'b111, 32'h200, 4'd7, 16'h1234, 1'b0));
    tick();
    drive_push(mk(32'h4, 32'h5, 32'h6, 4'd4, 4'd5, 4'd6, 3'b111, 32'h300, 4'd8, 16'h4321, 1'b0));
    #1 chk("b2b_d_ready", {127'd0, bus.d_ready}, 128'd1);
    tick();
    chk("b2b_e_valid", {127'd0, bus.e_valid}, 128'd1);
    chk("b2b_e_imm",   {96'd0, bus.e_imm}, 128'h300);
    bus.d_valid = 1'b0;
    tick();

    // Load-use hazard: load r3 held, consumer uses r3 in slot 1
    bus.e_ready = 1'b0;
    drive_push(mk(32'h0, 32'h0, 32'h0, 4'd0, 4'd0, 4'd0, 3'b000, 32'h400, 4'd3, 16'h0040, 1'b1));
    tick();
    x = mk(32'hC2, 32'hC1, 32'hC0, 4'd7, 4'd3, 4'd1, 3'b111, 32'h500, 4'd3, 16'h0001, 1'b0);
    drive(x);
    bus.e_ready = 1'b1;
    #1 chk("lu_hazard", {127'd0, bus.hazard}, 128'd1);
    chk("lu_d_ready", {127'd0, bus.d_ready}, 128'd0);
    tick();
    chk("lu_bubble", {127'd0, bus.e_valid}, 128'd0);
    chk("lu_stall",  {112'd0, bus.stall_cnt}, 128'd1);
    chk("lu_ready2", {127'd0, bus.d_ready}, 128'd1);
    sb.push_back(model(x, 1'b0, 4'd0, 32'd0));
    tick();
    chk("lu_capt_valid", {127'd0, bus.e_valid}, 128'd1);
    chk("lu_capt_imm",   {96'd0, bus.e_imm}, 128'h500);
    // Held non-load writing r3: a consumer of r3 is not a hazard
    bus.e_ready = 1'b0;
    drive(mk(32'h0, 32'h0, 32'h0, 4'd3, 4'd3, 4'd3, 3'b111, 32'h0, 4'd0, 16'h0, 1'b0));
    #1 chk("nonload_hazard", {127'd0, bus.hazard}, 128'd0);
    bus.d_valid = 1'b0; bus.e_ready = 1'b1;
    tick();
    chk("lu_stall_keep", {112'd0, bus.stall_cnt}, 128'd1);

    // Bypass while holding: slot 0 = r5 = 0x11, writeback r5 = 0xABCD
    bus.e_ready = 1'b0;
    drive_push(mk(32'h13, 32'h12, 32'h11, 4'd7, 4'd6, 4'd5, 3'b111, 32'h600, 4'd1, 16'h0, 1'b0));
    tick();
    bus.d_valid = 1'b0;
    bus.wb_we = 1'b1; bus.wb_wa = 4'd5; bus.wb_wd = 32'hABCD;
    t = sb.pop_back(); t.rd[31:0] = 32'hABCD; sb.push_back(t);
    tick();
    bus.wb_we = 1'b0;
    chk("hold_byp_s0",  {96'd0, bus.e_rd[31:0]}, 128'hABCD);
    chk("hold_byp_s1",  {96'd0, bus.e_rd[63:32]}, 128'h12);

    // Capture bypass on several matching slots; unused slot untouched
    bus.e_ready = 1'b1;
    bus.wb_we = 1'b1; bus.wb_wa = 4'd9; bus.wb_wd = 32'h5555;
    drive_push(mk(32'hA2, 32'hA1, 32'hA0, 4'd9, 4'd9, 4'd9, 3'b011, 32'h700, 4'd2, 16'h0, 1'b0));
    tick();
    chk("multi_byp", {32'd0, bus.e_rd}, {32'd0, 96'h000000A2_00005555_00005555});

    // PC alias is never bypassed
    bus.wb_wa = 4'd15; bus.wb_wd = 32'h1234;
    drive_push(mk(32'hCAFE, 32'h2, 32'h1, 4'd15, 4'd1, 4'd2, 3'b111, 32'h800, 4'd4, 16'h0, 1'b0));
    tick();
    chk("pc_no_byp", {96'd0, bus.e_rd[95:64]}, 128'hCAFE);
    bus.wb_we = 1'b0; bus.d_valid = 1'b0;
    tick();

    // Flush overrides a pending hazard and squashes the held load
    bus.e_ready = 1'b0;
    drive_push(mk(32'h0, 32'h0, 32'h0, 4'd0, 4'd0, 4'd0, 3'b000, 32'h900, 4'd8, 16'h0, 1'b1));
    tick();
    drive(mk(32'h0, 32'h0, 32'h0, 4'd0, 4'd8, 4'd0, 3'b010, 32'hA00, 4'd1, 16'h0, 1'b0));
    #1 chk("fl_pre_hazard", {127'd0, bus.hazard}, 128'd1);
    bus.flush = 1'b1;
    #1 chk("fl_hazard",  {127'd0, bus.hazard}, 128'd0);
    chk("fl_d_ready", {127'd0, bus.d_ready}, 128'd1);
    t = sb.pop_back();
    tick();
    chk("fl_e_valid", {127'd0, bus.e_valid}, 128'd0);
    chk("fl_stall",   {112'd0, bus.stall_cnt}, 128'd1);
    bus.flush = 1'b0; bus.d_valid = 1'b0;

    // Long stall: counter saturates at 0xFFFF
    drive_push(mk(32'h0, 32'h0, 32'h0, 4'd0, 4'd0, 4'd0, 3'b000, 32'hB00, 4'd10, 16'h0, 1'b1));
    tick();
    drive(mk(32'h0, 32'h0, 32'h0, 4'd0, 4'd0, 4'd10, 3'b001, 32'hC00, 4'd1, 16'h0, 1'b0));
    #1 chk("sat_hazard", {127'd0, bus.hazard}, 128'd1);
    repeat (65533) @(posedge clk);
    #1 chk("sat_fffe", {112'd0, bus.stall_cnt}, 128'hFFFE);
    repeat (4467) @(posedge clk);
    #1 chk("sat_ffff", {112'd0, bus.stall_cnt}, 128'hFFFF);

    // Reset mid-hold drops the held instruction
    reset = 1'b0;
    #1 chk("rst_mid_hazard",  {127'd0, bus.hazard}, 128'd0);
    chk("rst_mid_d_ready", {127'd0, bus.d_ready}, 128'd0);
    tick();
    chk("rst_mid_e_valid", {127'd0, bus.e_valid}, 128'd0);
    chk("rst_mid_stall",   {112'd0, bus.stall_cnt}, 128'd0);
    chk("rst_mid_e_imm",   {96'd0, bus.e_imm}, 128'd0);
    sb.delete();
    reset = 1'b1; bus.d_valid = 1'b0;
    tick();

    // Post-reset transfer still works
    bus.e_ready = 1'b1;
    drive_push(mk(32'h77, 32'h66, 32'h55, 4'd1, 4'd2, 4'd3, 3'b111, 32'hD00, 4'd6, 16'hBEEF, 1'b0));
    tick();
    bus.d_valid = 1'b0;
    tick();
    chk("sb_drained", {96'd0, 32'(sb.size())}, 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
